// File: rtl/bitwise_sched.sv
// Round-robin shared bitwise/shift unit.
// IDLE grants one requester, EXEC computes, RESP holds the result.
module bitwise_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [2:0]       cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [IDW-1:0]   cap_id;

  logic             found;
  int               gj;
  logic [IDW-1:0]   gnt_idx;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] res;
  logic             err;
  logic [IDW-1:0]   ptr_nxt;

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    found = 1'b0;
    gj    = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        gj    = (int'(ptr) + k) % NREQ;
      end
    end
    gnt_idx = IDW'(gj);
    op_sel  = req_op[gj*3 +: 3];
    a_sel   = req_a[gj*WIDTH +: WIDTH];
    b_sel   = req_b[gj*WIDTH +: WIDTH];
  end

  // Accept strobe only in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst && state == IDLE && found)
      req_ready = NREQ'(1) << gj;
  end

  // Operation on captured operands; oversize shifts give zero.
  always_comb begin
    res = '0;
    err = 1'b0;
    unique case (1'b1)
      cap_op == OP_AND: res = cap_a & cap_b;
      cap_op == OP_OR:  res = cap_a | cap_b;
      cap_op == OP_XOR: res = cap_a ^ cap_b;
      cap_op == OP_SHR:
        res = (cap_b >= WIDTH'(WIDTH)) ? '0 : cap_a >> cap_b;
      cap_op == OP_SHL:
        res = (cap_b >= WIDTH'(WIDTH)) ? '0 : cap_a << cap_b;
      default: begin
        res = '0;
        err = 1'b1;
      end
    endcase
  end

  // Pointer moves past the requester just served.
  always_comb begin
    ptr_nxt = (cap_id == IDW'(NREQ-1)) ? '0 : cap_id + IDW'(1);
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cap_op    <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cap_op <= op_sel;
            cap_a  <= a_sel;
            cap_b  <= b_sel;
            cap_id <= gnt_idx;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= res;
          rsp_err   <= err;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= ptr_nxt;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_sched.sv
// Directed bench for bitwise_sched.
// Vector table plus reset, round-robin and backpressure sequences.
module tb_bitwise_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       e;
  } vec_t;

  vec_t vecs[12];
  vec_t v;

  bitwise_sched #(.WIDTH(8), .NREQ(4)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Same AND operation on every requester; result is 8'h10+i.
  task automatic set_all();
    for (int i = 0; i < 4; i++) begin
      req_op[3*i +: 3] = 3'd0;
      req_a[8*i +: 8]  = 8'h10 + 8'(i);
      req_b[8*i +: 8]  = 8'hFF;
    end
  endtask

  task automatic run_vec(input vec_t x);
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_valid[x.id]       = 1'b1;
    req_op[3*x.id +: 3]   = x.op;
    req_a[8*x.id +: 8]    = x.a;
    req_b[8*x.id +: 8]    = x.b;
    rsp_ready = 1'b1;
    #1;
    chk("grant", req_ready, 32'(4'b1 << x.id));
    step();
    req_valid = '0;
    req_op    = ~req_op;
    req_a     = ~req_a;
    req_b     = ~req_b;
    chk("exec_ready", req_ready, 0);
    chk("exec_valid", rsp_valid, 0);
    step();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, x.id);
    chk("rsp_data", rsp_data, x.d);
    chk("rsp_err", rsp_err, x.e);
    step();
    chk("done_valid", rsp_valid, 0);
  endtask

  initial begin
    vecs[0]  = '{1, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1]  = '{0, 3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    vecs[2]  = '{3, 3'd2, 8'hAA, 8'hFF, 8'h55, 1'b0};
    vecs[3]  = '{2, 3'd3, 8'h80, 8'h03, 8'h10, 1'b0};
    vecs[4]  = '{1, 3'd4, 8'h81, 8'h01, 8'h02, 1'b0};
    vecs[5]  = '{0, 3'd4, 8'h81, 8'h08, 8'h00, 1'b0};
    vecs[6]  = '{3, 3'd4, 8'h81, 8'hFF, 8'h00, 1'b0};
    vecs[7]  = '{2, 3'd3, 8'hFF, 8'h07, 8'h01, 1'b0};
    vecs[8]  = '{2, 3'd6, 8'h12, 8'h34, 8'h00, 1'b1};
    vecs[9]  = '{0, 3'd5, 8'hFF, 8'hFF, 8'h00, 1'b1};
    vecs[10] = '{1, 3'd7, 8'h0F, 8'hF0, 8'h00, 1'b1};
    vecs[11] = '{3, 3'd3, 8'hFF, 8'h08, 8'h00, 1'b0};

    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_ready", req_ready, 0);
    step();
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i]);

    // Serve requester 2 so the pointer sits at 3.
    v = '{2, 3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0};
    run_vec(v);

    // All valid: ptr=3 grants requester 3; reset hits in EXEC.
    set_all();
    req_valid = 4'b1111;
    #1;
    chk("ptr3_grant", req_ready, 4'b1000);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_err", rsp_err, 0);
    chk("mid_rst_ready", req_ready, 0);
    step();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("no_stale", rsp_valid, 0);
      step();
    end

    // Continuous requests: strict 0,1,2,3 rotation, 3 cycles each.
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", req_ready, 32'(4'b1 << (k % 4)));
      step();
      chk("rr_exec", req_ready, 0);
      step();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, k % 4);
      chk("rr_data", rsp_data, 8'h10 + 8'(k % 4));
      step();
    end

    // Backpressure: result held while others wait.
    req_valid        = 4'b1000;
    req_op[9 +: 3]   = 3'd1;
    req_a[24 +: 8]   = 8'h0C;
    req_b[24 +: 8]   = 8'h30;
    rsp_ready        = 1'b0;
    #1;
    chk("bp_grant", req_ready, 4'b1000);
    step();
    req_valid = 4'b0111;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 8'h3C);
      chk("bp_id", rsp_id, 3);
      chk("bp_ready", req_ready, 0);
      step();
    end
    chk("bp_hold", rsp_valid, 1);
    rsp_ready = 1'b1;
    step();
    chk("bp_done", rsp_valid, 0);
    chk("bp_next", req_ready, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitwise_sched.md
BITWISE_SCHED -- requirements
Module: bitwise_sched

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits (at least 2).
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters sharing the unit (2..8).
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  SHALL carry the per-requester request-pending flag.
REQ-006 req_ready  output  NREQ  SHALL carry the per-requester accept strobe, at most one bit high per cycle.
REQ-007 req_op  input  3*NREQ  SHALL carry the per-requester opcode, with requester i in bits [3i+2:3i].
REQ-008 req_a  input  WIDTH*NREQ  SHALL carry the per-requester operand A, packed as for req_op.
REQ-009 req_b  input  WIDTH*NREQ  SHALL carry the per-requester operand B or shift amount, packed as for req_op.
REQ-010 rsp_valid  output  1  SHALL indicate that a result is held.
REQ-011 rsp_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-012 rsp_id  output  clog2(NREQ)  SHALL carry the index of the requester that owns the result.
REQ-013 rsp_data  output  WIDTH  SHALL carry the result value.
REQ-014 rsp_err  output  1  SHALL flag an illegal opcode.

Function
REQ-015 The opcode set SHALL be: 0 AND a&b; 1 OR a|b; 2 XOR a^b; 3 SHR logical a>>b; 4 SHL a<<b; 5..7 illegal.
REQ-016 For SHR and SHL, the full WIDTH-bit value of b SHALL be the shift amount, and any b >= WIDTH SHALL give a result of 0.
REQ-017 An illegal opcode SHALL give rsp_data=0 and rsp_err=1; a legal opcode SHALL give rsp_err=0.
REQ-018 The FSM SHALL have three states, IDLE, EXEC and RESP; reset SHALL enter IDLE.
REQ-019 In IDLE with any req_valid high, the block SHALL, in that same cycle, drive req_ready high combinationally for exactly one granted requester.
REQ-020 On the same clock edge as REQ-019, the block SHALL capture that requester's op, a, b and index, and move to EXEC.
REQ-021 In IDLE with no req_valid high, req_ready SHALL be all zero and the FSM SHALL stay in IDLE.
REQ-022 The grant SHALL be round-robin: search starts at pointer ptr, covers ptr, ptr+1, ... modulo NREQ, and the first valid requester wins.
REQ-023 ptr SHALL reset to 0 and SHALL update to (granted index + 1) mod NREQ on the edge that leaves RESP.
REQ-024 In EXEC, the result SHALL be computed from the captured operands and registered into rsp_data, rsp_err and rsp_id, and the FSM SHALL move to RESP.
REQ-025 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_err and rsp_id SHALL stay stable until a cycle with rsp_ready=1.
REQ-026 On the edge of a RESP cycle with rsp_ready=1, the FSM SHALL go to IDLE and rsp_valid SHALL fall.
REQ-027 req_ready SHALL be 0 in EXEC and RESP; changes on requester inputs after acceptance SHALL NOT affect the pending result.
REQ-028 Latency SHALL be: a request accepted at edge T presents rsp_valid=1 from edge T+1 (RESP entered); with rsp_ready held high, one operation completes every 3 cycles.
REQ-029 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-030 A requester that deasserts req_valid while not granted SHALL lose nothing; no request SHALL be queued internally.
REQ-031 With all NREQ requesters valid continuously, each SHALL be served exactly once per NREQ grants, in ascending cyclic order.

Reset
REQ-032 Assertion of rst SHALL immediately, regardless of clk, force: FSM=IDLE, ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, req_ready=0.
REQ-033 Reset asserted mid-operation (in EXEC or RESP) SHALL discard the in-flight result, which SHALL never be presented.
REQ-034 After rst deasserts, the first grant SHALL follow REQ-022 with ptr=0.

Verification
REQ-035 Scenario: requester 1 only, op=0, a=8'hF0, b=8'h3C, rsp_ready=1 -> req_ready[1] pulses once; rsp_valid, rsp_id=1, rsp_data=8'h30, rsp_err=0.
REQ-036 Scenario: ops SHR a=8'h80,b=3 and SHL a=8'h81,b=1 -> 8'h10 and 8'h02; SHL with b=8 or b=8'hFF -> 8'h00.
REQ-037 Scenario: all four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,...; each operation completes in 3 cycles.
REQ-038 Scenario: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable; no new req_ready; completes on the cycle rsp_ready=1.
REQ-039 Scenario: op=6 from requester 2 -> rsp_err=1, rsp_data=0, rsp_id=2.
REQ-040 Scenario: rst low during EXEC -> all outputs 0 asynchronously; after release no stale response; requester 0 is granted first.
